// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issue sequencer feeding a registered-control ALU
//
// Accepts decoded R-type operations over in_valid/in_ready, drives the ALU's
// dataA/dataB/Signal inputs (all registered), waits out the ALU control latency
// or the multi-cycle MULTU, and captures the ALU Output into a held result.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          operation offer / accept (ready only in IDLE)
//   in_funct/rs/rt/shamt/rd    decoded operation fields
//   alu_dataA/B, alu_signal    registered ALU drive
//   alu_output                 ALU result
//   res_valid/res_ready        result handshake, res_data/res_rd held in RESP
//   mult_done, illegal         one-cycle status pulses
//   busy                       sequencer not idle
module alu_issue_seq #(
  parameter int DATA_W   = 32,
  parameter int ALU_LAT  = 1,
  parameter int MULT_LAT = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_rd,
  output logic [DATA_W-1:0] alu_dataA,
  output logic [DATA_W-1:0] alu_dataB,
  output logic [5:0]        alu_signal,
  input  logic [DATA_W-1:0] alu_output,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [4:0]        res_rd,
  output logic              mult_done,
  output logic              illegal,
  output logic              busy
);

  localparam int MAX_LAT = (MULT_LAT > ALU_LAT + 1) ? MULT_LAT : ALU_LAT + 1;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // Last counter value in each timed state; the transition happens on that edge.
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LAT - 1);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  typedef enum logic [1:0] {IDLE, EXEC, RESP, MULT} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             isLegal;

  always_comb begin
    isLegal = 1'b0;
    case (in_funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT,
      F_SRL, F_MULTU, F_MFHI, F_MFLO: isLegal = 1'b1;
      default:                        isLegal = 1'b0;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      alu_dataA  <= '0;
      alu_dataB  <= '0;
      alu_signal <= 6'b000000;
      res_data   <= '0;
      res_valid  <= 1'b0;
      res_rd     <= '0;
      mult_done  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      mult_done <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!isLegal) begin
              illegal <= 1'b1;
            end else begin
              // SRL shifts rt by shamt; the ALU takes the shift source on dataA.
              if (in_funct == F_SRL) begin
                alu_dataA <= in_rt;
                alu_dataB <= {{(DATA_W-5){1'b0}}, in_shamt};
              end else begin
                alu_dataA <= in_rs;
                alu_dataB <= in_rt;
              end
              alu_signal <= in_funct;
              res_rd     <= in_rd;
              counter    <= '0;
              state      <= (in_funct == F_MULTU) ? MULT : EXEC;
            end
          end
        end
        EXEC: begin
          if (counter == EXEC_LAST) begin
            res_data  <= alu_output;
            res_valid <= 1'b1;
            counter   <= '0;
            state     <= RESP;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            alu_signal <= 6'b000000;
            state      <= IDLE;
          end
        end
        MULT: begin
          // MULTU stays on Signal for exactly MULT_LAT cycles so HI/LO settle.
          if (counter == MULT_LAST) begin
            alu_signal <= 6'b000000;
            mult_done  <= 1'b1;
            counter    <= '0;
            state      <= IDLE;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - self-checking bench for alu_issue_seq
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_funct = 6'd0;
  logic [31:0] in_rs = 32'd0;
  logic [31:0] in_rt = 32'd0;
  logic [4:0]  in_shamt = 5'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_output;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        mult_done;
  logic        illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_rd(in_rd),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
    .alu_output(alu_output),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .mult_done(mult_done), .illegal(illegal), .busy(busy)
  );

  // ALU model: registered control decode, HI/LO written on the 33rd MULTU cycle.
  logic [5:0]  sigReg;
  logic [31:0] hiReg, loReg;
  int          multCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sigReg  <= 6'd0;
      multCnt <= 0;
      hiReg   <= 32'd0;
      loReg   <= 32'd0;
    end else begin
      sigReg <= alu_signal;
      if (alu_signal == 6'd25) begin
        if (multCnt == 32) {hiReg, loReg} <= 64'(alu_dataA) * 64'(alu_dataB);
        multCnt <= multCnt + 1;
      end else begin
        multCnt <= 0;
      end
    end
  end

  always_comb begin
    alu_output = 32'd0;
    case (sigReg)
      6'd36: alu_output = alu_dataA & alu_dataB;
      6'd37: alu_output = alu_dataA | alu_dataB;
      6'd32: alu_output = alu_dataA + alu_dataB;
      6'd34: alu_output = alu_dataA - alu_dataB;
      6'd42: alu_output = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
      6'd2:  alu_output = alu_dataA >> alu_dataB[4:0];
      6'd16: alu_output = hiReg;
      6'd18: alu_output = loReg;
      default: alu_output = 32'd0;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Single non-MULTU operation with fixed timing; res_ready raised once result seen.
  task automatic doOp(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] sh, input logic [4:0] rd, input logic [31:0] exp,
                      input string nm);
    @(negedge clk);
    check({nm, " ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_funct = f; in_rs = rs; in_rt = rt; in_shamt = sh; in_rd = rd;
    res_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, " signal"}, 32'(alu_signal), 32'(f));
    check({nm, " dataA"}, alu_dataA, (f == 6'd2) ? rt : rs);
    check({nm, " dataB"}, alu_dataB, (f == 6'd2) ? 32'(sh) : rt);
    check({nm, " ready_low"}, 32'(in_ready), 32'd0);
    check({nm, " busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({nm, " res_valid_early"}, 32'(res_valid), 32'd0);
    @(negedge clk);
    check({nm, " res_valid"}, 32'(res_valid), 32'd1);
    check({nm, " res_data"}, res_data, exp);
    check({nm, " res_rd"}, 32'(res_rd), 32'(rd));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({nm, " res_valid_drop"}, 32'(res_valid), 32'd0);
    check({nm, " ready_after"}, 32'(in_ready), 32'd1);
    check({nm, " signal_idle"}, 32'(alu_signal), 32'd0);
  endtask

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int sigCnt, doneCnt, validCnt, waitCnt, issued;
    logic acc;
    logic [31:0] got[$];

    vecs[0] = '{6'd32, 32'd5,          32'd7,          5'd0, 5'd3,  32'd12,         "add_5_7"};
    vecs[1] = '{6'd34, 32'd3,          32'd5,          5'd0, 5'd4,  32'hFFFF_FFFE,  "sub_3_5"};
    vecs[2] = '{6'd36, 32'hF0F0_1234,  32'h0FF0_FFFF,  5'd0, 5'd5,  32'h00F0_1234,  "and"};
    vecs[3] = '{6'd37, 32'hF000_0000,  32'h0000_000F,  5'd0, 5'd6,  32'hF000_000F,  "or"};
    vecs[4] = '{6'd42, 32'hFFFF_FFFF,  32'd1,          5'd0, 5'd7,  32'd1,          "slt_m1_1"};
    vecs[5] = '{6'd42, 32'd1,          32'hFFFF_FFFF,  5'd0, 5'd0,  32'd0,          "slt_1_m1_rd0"};
    vecs[6] = '{6'd2,  32'h1234_5678,  32'hFFFF_0000,  5'd8, 5'd31, 32'h00FF_FF00,  "srl_8"};

    // Reset state
    #12;
    check("rst alu_signal", 32'(alu_signal), 32'd0);
    check("rst dataA", alu_dataA, 32'd0);
    check("rst dataB", alu_dataB, 32'd0);
    check("rst res_data", res_data, 32'd0);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_rd", 32'(res_rd), 32'd0);
    check("rst mult_done", 32'(mult_done), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      doOp(vecs[i].funct, vecs[i].rs, vecs[i].rt, vecs[i].shamt, vecs[i].rd, vecs[i].exp, vecs[i].name);

    // SRL with writeback stalled for 5 cycles
    @(negedge clk);
    in_valid = 1'b1; in_funct = 6'd2; in_rs = 32'hDEAD_BEEF; in_rt = 32'h8000_0000;
    in_shamt = 5'd4; in_rd = 5'd12; res_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("srl dataA", alu_dataA, 32'h8000_0000);
    check("srl dataB", alu_dataB, 32'd4);
    waitCnt = 0;
    while (!res_valid && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    for (int i = 0; i < 5; i++) begin
      check("srl stall valid", 32'(res_valid), 32'd1);
      check("srl stall data", res_data, 32'h0800_0000);
      check("srl stall ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("srl idle after ready", 32'(in_ready), 32'd1);
    check("srl valid dropped", 32'(res_valid), 32'd0);

    // MULTU 0xFFFFFFFF * 2
    @(negedge clk);
    in_valid = 1'b1; in_funct = 6'd25; in_rs = 32'hFFFF_FFFF; in_rt = 32'd2; in_rd = 5'd1;
    @(negedge clk);
    in_valid = 1'b0;
    sigCnt = 0; doneCnt = 0; validCnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (alu_signal == 6'd25) sigCnt++;
      if (mult_done) doneCnt++;
      if (res_valid) validCnt++;
      @(negedge clk);
    end
    check("multu signal cycles", 32'(sigCnt), 32'd33);
    check("multu done pulses", 32'(doneCnt), 32'd1);
    check("multu no res_valid", 32'(validCnt), 32'd0);
    check("multu idle", 32'(in_ready), 32'd1);
    doOp(6'd16, 32'd0, 32'd0, 5'd0, 5'd2, 32'd1, "mfhi");
    doOp(6'd18, 32'd0, 32'd0, 5'd0, 5'd3, 32'hFFFF_FFFE, "mflo");

    // Illegal funct
    @(negedge clk);
    in_valid = 1'b1; in_funct = 6'h3F; in_rs = 32'd9; in_rt = 32'd9; in_rd = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    check("illegal pulse", 32'(illegal), 32'd1);
    check("illegal in_ready", 32'(in_ready), 32'd1);
    check("illegal signal", 32'(alu_signal), 32'd0);
    check("illegal res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("illegal pulse end", 32'(illegal), 32'd0);
    check("illegal no result", 32'(res_valid), 32'd0);

    // Back-to-back SLT then SUB with offer held and writeback always ready
    @(negedge clk);
    res_ready = 1'b1;
    in_valid = 1'b1; in_funct = 6'd42; in_rs = 32'hFFFF_FFFF; in_rt = 32'd1; in_rd = 5'd10;
    issued = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 2; cyc++) begin
      acc = in_valid && in_ready;
      if (res_valid && res_ready) got.push_back(res_data);
      if (acc && issued == 1) check("b2b second gated", 32'(got.size()), 32'd1);
      @(posedge clk);
      #1;
      if (acc) begin
        issued++;
        if (issued == 1) begin
          in_funct = 6'd34; in_rs = 32'd3; in_rt = 32'd5; in_rd = 5'd11;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    res_ready = 1'b0;
    check("b2b result count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check("b2b first slt", got[0], 32'd1);
      check("b2b second sub", got[1], 32'hFFFF_FFFE);
    end

    // Reset in the middle of MULTU
    @(negedge clk);
    in_valid = 1'b1; in_funct = 6'd25; in_rs = 32'd7; in_rt = 32'd7; in_rd = 5'd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midmult signal", 32'(alu_signal), 32'd25);
    #2 reset = 1'b1;
    #1;
    check("midrst signal", 32'(alu_signal), 32'd0);
    check("midrst dataA", alu_dataA, 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (mult_done) doneCnt++;
      @(negedge clk);
    end
    check("midrst no mult_done", 32'(doneCnt), 32'd0);
    doOp(6'd32, 32'd1, 32'd1, 5'd0, 5'd13, 32'd2, "add_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
